// File: rtl/alu_issue_queue.sv
// Issue queue in front of the clocked ALU: buffers decoded ops, issues one per cycle,
// and carries each op's destination tag alongside the ALU latency for writeback.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [11:0]              in_alusignals,
  input  logic [15:0]              in_op1,
  input  logic [15:0]              in_op2,
  input  logic [4:0]               in_immx,
  input  logic                     in_isimmediate,
  input  logic [3:0]               in_rd,
  input  logic                     issue_en,
  input  logic                     flush,
  output logic [11:0]              alusignals,
  output logic [15:0]              op1,
  output logic [15:0]              op2,
  output logic [4:0]               immx,
  output logic                     isimmediate,
  input  logic [15:0]              aluresult,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [3:0]               wb_rd,
  output logic [15:0]              wb_data,
  output logic                     illegal_op,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [11:0] sig;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  immx;
    logic        isimm;
    logic [3:0]  rd;
  } entry_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [3:0] rd;
  } tag_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head_reg;
  logic [AW-1:0]   tail_reg;
  logic [AW:0]     count_reg;
  tag_t            pipe_reg [ALU_LAT];

  entry_t          head_entry;
  logic            push;
  logic            pop;
  logic            legal;
  logic            issue;
  logic            issue_we;
  tag_t            pipe_tail;

  assign in_ready   = (count_reg != FULL_COUNT);
  assign push       = in_valid && in_ready && !flush;
  assign pop        = (count_reg != '0) && issue_en && !flush;
  assign head_entry = mem[head_reg];
  assign legal      = $onehot(head_entry.sig);
  assign issue      = pop && legal;
  // st (bit 2) and cmp (bit 5) produce no register write
  assign issue_we   = !(head_entry.sig[2] || head_entry.sig[5]);
  assign count      = count_reg;

  // Storage is write-only here; the head is read combinationally so a pushed
  // entry can issue on the very next edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= '{sig: in_alusignals, op1: in_op1, op2: in_op2,
                         immx: in_immx, isimm: in_isimmediate, rd: in_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      alusignals  <= '0;
      op1         <= '0;
      op2         <= '0;
      immx        <= '0;
      isimmediate <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (flush) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      alusignals  <= '0;
      illegal_op  <= 1'b0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      illegal_op <= pop && !legal;
      alusignals <= issue ? head_entry.sig : '0;
      // Operand fields only change on a real issue so the ALU sees stable data otherwise
      if (issue) begin
        op1         <= head_entry.op1;
        op2         <= head_entry.op2;
        immx        <= head_entry.immx;
        isimmediate <= head_entry.isimm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < ALU_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= issue ? tag_t'{valid: 1'b1, we: issue_we, rd: head_entry.rd} : '0;
      for (int i = 1; i < ALU_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign pipe_tail = pipe_reg[ALU_LAT-1];
  assign wb_valid  = pipe_tail.valid && !flush;
  assign wb_we     = wb_valid && pipe_tail.we;
  assign wb_rd     = wb_valid ? pipe_tail.rd : '0;
  assign wb_data   = aluresult;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: queue-based reference model predicts issues and
// writebacks; a negedge monitor compares the DUT against it every cycle.
module tb_alu_issue_queue;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_alusignals;
  logic [15:0] in_op1, in_op2;
  logic [4:0]  in_immx;
  logic        in_isimmediate;
  logic [3:0]  in_rd;
  logic        issue_en;
  logic        flush;
  logic [11:0] alusignals;
  logic [15:0] op1, op2;
  logic [4:0]  immx;
  logic        isimmediate;
  logic [15:0] aluresult;
  logic        wb_valid, wb_we;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal_op;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alusignals(in_alusignals), .in_op1(in_op1), .in_op2(in_op2),
    .in_immx(in_immx), .in_isimmediate(in_isimmediate), .in_rd(in_rd),
    .issue_en(issue_en), .flush(flush),
    .alusignals(alusignals), .op1(op1), .op2(op2), .immx(immx),
    .isimmediate(isimmediate), .aluresult(aluresult),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal_op(illegal_op), .count(count)
  );

  function automatic logic [15:0] alu_f(input logic [11:0] s, input logic [15:0] a,
                                        input logic [15:0] b_in, input logic [4:0] im,
                                        input logic isim);
    logic [15:0] b;
    b = isim ? {11'd0, im} : b_in;
    case (s)
      12'h001, 12'h002, 12'h004: return a + b;
      12'h008, 12'h020:          return a - b;
      12'h010:                   return a * b;
      12'h040:                   return b;
      12'h080:                   return a | b;
      12'h100:                   return a & b;
      12'h200:                   return ~a;
      12'h400:                   return a << b[3:0];
      12'h800:                   return a >> b[3:0];
      default:                   return 16'h0000;
    endcase
  endfunction

  // Stand-in for the single-cycle ALU: result is valid while the bundle is presented
  assign aluresult = alu_f(alusignals, op1, op2, immx, isimmediate);

  typedef struct {
    logic [11:0] sig;
    logic [15:0] op1, op2;
    logic [4:0]  immx;
    logic        imm;
    logic [3:0]  rd;
  } op_t;

  typedef struct {
    int          due;
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
  } wb_t;

  op_t  mq[$];
  wb_t  inflight[$];
  logic [11:0] e_sig = '0;
  logic [15:0] e_op1 = '0, e_op2 = '0;
  logic [4:0]  e_immx = '0;
  logic        e_imm = 1'b0;
  logic        e_ill = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: advances on each edge from the inputs sampled at that edge
  always @(posedge clk) begin
    bit do_pop, do_push;
    op_t o;
    wb_t w;
    cyc++;
    if (rst) begin
      mq.delete();
      inflight.delete();
      e_sig = '0; e_op1 = '0; e_op2 = '0; e_immx = '0; e_imm = 1'b0; e_ill = 1'b0;
    end else begin
      do_pop  = (mq.size() > 0) && issue_en && !flush;
      do_push = in_valid && (mq.size() < DEPTH) && !flush;
      e_sig = '0;
      e_ill = 1'b0;
      if (flush) begin
        mq.delete();
        inflight.delete();
      end
      if (do_pop) begin
        o = mq.pop_front();
        if ($countones(o.sig) == 1) begin
          e_sig = o.sig; e_op1 = o.op1; e_op2 = o.op2; e_immx = o.immx; e_imm = o.imm;
          w.due  = cyc + ALU_LAT - 1;
          w.we   = !(o.sig == 12'h004 || o.sig == 12'h020);
          w.rd   = o.rd;
          w.data = alu_f(o.sig, o.op1, o.op2, o.immx, o.imm);
          inflight.push_back(w);
        end else begin
          e_ill = 1'b1;
        end
      end
      if (do_push) begin
        o.sig = in_alusignals; o.op1 = in_op1; o.op2 = in_op2;
        o.immx = in_immx; o.imm = in_isimmediate; o.rd = in_rd;
        mq.push_back(o);
      end
    end
  end

  // Monitor: mid-cycle comparison of every observable output
  always @(negedge clk) begin
    bit  exp_v;
    wb_t w;
    if (!rst) begin
      check("count", 64'(count), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      check("bundle", 64'({alusignals, op1, op2, immx, isimmediate}),
            64'({e_sig, e_op1, e_op2, e_immx, e_imm}));
      check("illegal_op", 64'(illegal_op), 64'(e_ill));
      exp_v = 1'b0;
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        w = inflight.pop_front();
        exp_v = !flush;
      end
      if (exp_v)
        check("writeback", 64'({wb_valid, wb_we, wb_rd, wb_data}),
              64'({1'b1, w.we, w.rd, w.data}));
      else
        check("wb_idle", 64'({wb_valid, wb_we, wb_rd}), 64'(0));
    end
  end

  task automatic drive(input logic v, input logic [11:0] s, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] im, input logic isim,
                       input logic [3:0] rd, input logic ie, input logic fl);
    in_valid = v; in_alusignals = s; in_op1 = a; in_op2 = b; in_immx = im;
    in_isimmediate = isim; in_rd = rd; issue_en = ie; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ie);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, 1'b0, '0, ie, 1'b0);
  endtask

  task automatic push_rand(input logic [11:0] s, input logic ie);
    drive(1'b1, s, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
          4'($urandom), ie, 1'b0);
  endtask

  initial begin
    logic [11:0] s;
    rst = 1'b1;
    in_valid = 1'b0; in_alusignals = '0; in_op1 = '0; in_op2 = '0; in_immx = '0;
    in_isimmediate = 1'b0; in_rd = '0; issue_en = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1, 1'b0);

    // single add 5+3 -> rd 2
    drive(1'b1, 12'h001, 16'h0005, 16'h0003, 5'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    idle(3, 1'b1);

    // fill with issue held off; fifth offer must be refused
    for (int i = 0; i < 5; i++) begin
      s = 12'h001 << (i + 6);
      push_rand(s, 1'b0);
    end
    idle(7, 1'b1);

    // cmp and st: writeback without register write
    drive(1'b1, 12'h020, 16'h0009, 16'h0004, 5'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    drive(1'b1, 12'h004, 16'h0100, 16'h0002, 5'd7, 1'b1, 4'd4, 1'b1, 1'b0);
    idle(3, 1'b1);

    // non-one-hot op followed by or
    drive(1'b1, 12'h003, 16'h1111, 16'h2222, 5'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    drive(1'b1, 12'h080, 16'h00f0, 16'h0f00, 5'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    idle(3, 1'b1);

    // flush while one op is in flight and two remain queued
    for (int i = 0; i < 3; i++) push_rand(12'h001 << i, 1'b0);
    idle(1, 1'b1);
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // reset mid-operation, then a fresh op
    for (int i = 0; i < 3; i++) push_rand(12'h010 << i, 1'b0);
    idle(1, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    drive(1'b1, 12'h040, 16'h0000, 16'hbeef, 5'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) != 0) s = 12'h001 << $urandom_range(0, 11);
      else                           s = 12'($urandom);
      drive(1'($urandom_range(0, 3) != 0), s, 16'($urandom), 16'($urandom),
            5'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    idle(DEPTH + 4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Buffers decoded ALU micro-ops from the decode stage and issues one per cycle to the clocked `alu` unit. It drives the ALU's `alusignals`, `op1`, `op2`, `immx` and `isimmediate` inputs. It tracks each in-flight op's destination tag through the ALU latency, then pairs the returned `aluresult` with that tag for writeback. It sits between decode and the `alu`, acting as the initiator for the ALU control interface.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `ALU_LAT`, 1: cycles from a registered issue to `aluresult` valid at this block's input; 1..4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: decode offers an op.
- `in_ready` out 1: queue can accept; high when not full.
- `in_alusignals` in 12: one-hot op select. Bit order, bit 0 to bit 11: add, ld, st, sub, mul, cmp, mov, or, and, not, lsl, lsr.
- `in_op1`, `in_op2` in 16: source operands.
- `in_immx` in 5: immediate.
- `in_isimmediate` in 1: use immediate in place of `op2`.
- `in_rd` in 4: destination tag.
- `issue_en` in 1: scheduler permits issue this cycle.
- `flush` in 1: discard all queued and in-flight ops.
- `alusignals` out 12, `op1` out 16, `op2` out 16, `immx` out 5, `isimmediate` out 1: registered ALU control bundle.
- `aluresult` in 16: result returned from the ALU.
- `wb_valid` out 1: writeback slot valid.
- `wb_we` out 1: register write enable.
- `wb_rd` out 4: destination tag for writeback.
- `wb_data` out 16: result data for writeback.
- `illegal_op` out 1: one-cycle pulse when a non-one-hot op is dropped.
- `count` out log2(DEPTH)+1: current occupancy.

## Operation
- **Queue:** circular FIFO with head/tail pointers that wrap modulo `DEPTH`.
- **Push:** occurs when `in_valid && in_ready`.
- **Pop:** occurs when the queue is non-empty, `issue_en` is high and `flush` is low.
- **Simultaneous push and pop when full:**
  - `in_ready` reflects the current cycle's full state only, so no push occurs while full.
  - When not full and empty, a push and a pop in the same cycle are not allowed to bypass. The entry must first be written, so issue happens at the earliest one cycle after the push.
- **Issue of a popped entry:**
  - If its `alusignals` has popcount 1, register the bundle onto the ALU outputs.
  - Otherwise (zero or multiple bits set), drive `alusignals`=0, pulse `illegal_op` and issue nothing into the tag pipe.
- **No pop:** `alusignals` is driven to 0 and the other bundle fields hold their previous values.
- **Tag pipe:** an `ALU_LAT`-stage shift register of {valid, we, rd}, loaded at issue.
  - `we` = 0 for st and cmp.
  - `we` = 1 for every other op.
- **Writeback:** when the tag-pipe tail is valid, `wb_valid`=1, `wb_we`/`wb_rd` come from the pipe, and `wb_data`=`aluresult` in that same cycle (combinational pass-through).
- **Flush:**
  - Pointers and `count` reset to 0 and all tag-pipe valids clear on the next edge.
  - `alusignals`=0 on the next edge.
  - A push in the flush cycle is discarded.
  - `wb_valid` is forced to 0 in the flush cycle itself.
- **Reset (including mid-operation):**
  - `count`=0, `in_ready`=1.
  - `alusignals`=0, `op1`=`op2`=0, `immx`=0, `isimmediate`=0.
  - `wb_valid`=0, `wb_we`=0, `wb_rd`=0.
  - `illegal_op`=0.
  - All tag-pipe valids cleared.
  - Reset takes priority over `flush`, push and pop.

## Timing
- Push at edge N:
  - Entry visible at the head at N+1.
  - Earliest issue: bundle on the ALU outputs after edge N+1.
- Issue at edge M:
  - `wb_valid` asserted in the cycle following edge M+`ALU_LAT`-1.
  - With `ALU_LAT`=1, that is the cycle immediately after the bundle appears.
- Throughput: one op per cycle while `issue_en` stays high.
- `in_ready` falls in the cycle `count` reaches `DEPTH`.
- `in_ready` rises the cycle after a pop from full.
- `illegal_op` asserts the cycle after the bad entry is popped and lasts exactly one cycle per bad entry.
- `count` updates each edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.

## Test plan
- **Single op:** push add with op1=0x0005, op2=0x0003, rd=2; `issue_en`=1.
  - Expect `alusignals`=0x001 one cycle later.
  - Expect `wb_valid`=1, `wb_rd`=2, `wb_we`=1 and `wb_data`=0x0008, following the `ALU_LAT` rule.
- **Fill and drain:** hold `issue_en`=0 and push 4 ops.
  - Expect `count`=4 and `in_ready`=0; a 5th offer is not accepted.
  - Raise `issue_en`: expect 4 issues on consecutive cycles in FIFO order, and `in_ready`=1 after the first pop.
- **No-write ops:** push cmp (0x020) and st (0x004).
  - Expect `wb_valid`=1 with `wb_we`=0 for both.
- **Illegal op:** push `alusignals`=0x003, then a legal or (0x080).
  - Expect one `illegal_op` pulse and no writeback for the illegal op.
  - Expect the or issued on the next cycle.
- **Flush:** push 3 ops, issue 1, assert `flush` while the issued op is in flight.
  - Expect `count`=0 and `wb_valid`=0 throughout, and `alusignals`=0 afterwards.
- **Mid-operation reset:** queue half full with an op in flight, assert `rst` for 1 cycle.
  - Expect all outputs at their reset values and `in_ready`=1.
  - Expect a fresh push to issue normally.
